// File: rtl/uart_tx_monitor_pkg.sv
// Shared types and constants for the UART transmit-line monitor.
// Optional 8E1 framing is enabled with UART_TX_MONITOR_PARITY_EN.
package uart_tx_monitor_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam int DATA_BITS = 8;
  localparam logic [7:0] EOT_DEFAULT = 8'h04;

endpackage

// File: rtl/uart_tx_monitor_fifo.sv
// Small synchronous byte FIFO with registered storage.
// Head is shown combinationally; an empty FIFO presents zero.
module uart_tx_monitor_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      used;
  logic             wr;
  logic             rd;

  assign rd    = pop & ~empty;
  // A push into a full FIFO only lands if a pop frees the slot.
  assign wr    = push & (~full | rd);
  assign full  = (used == (AW+1)'(DEPTH));
  assign empty = (used == '0);
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      used <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      unique case (1'b1)
        wr & ~rd: used <= used + 1'b1;
        rd & ~wr: used <= used - 1'b1;
        default:  used <= used;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_monitor.sv
// UART receiver for the SoC's pad_uart_tx line: 8N1 decode into a FIFO.
// Define UART_TX_MONITOR_PARITY_EN for 8E1 framing with even parity.
module uart_tx_monitor
  import uart_tx_monitor_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 1085,
  parameter int         FIFO_DEPTH   = 8,
  parameter logic [7:0] EOT_CHAR     = EOT_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rx_i,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        frame_err_o,
  output logic        overflow_o,
  output logic        eot_o,
  output logic        busy_o,
  output logic [15:0] rx_count_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
`ifdef UART_TX_MONITOR_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif

  logic rx_m, rx_s, rx_q, fall, tick;
  state_t state, state_d;
  logic [CW-1:0]        cnt, cnt_d;
  logic [IW-1:0]        idx, idx_d;
  logic [DATA_BITS-1:0] sh, sh_d;
  logic                 push, ferr;
  logic                 pop, full, empty, push_ok;
`ifdef UART_TX_MONITOR_PARITY_EN
  logic                 par, par_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  assign fall   = rx_q & ~rx_s;
  assign tick   = (cnt == '0);
  assign busy_o = (state != IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      sh    <= '0;
`ifdef UART_TX_MONITOR_PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      idx   <= idx_d;
      sh    <= sh_d;
`ifdef UART_TX_MONITOR_PARITY_EN
      par   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = tick ? cnt : cnt - 1'b1;
    idx_d   = idx;
    sh_d    = sh;
    push    = 1'b0;
    ferr    = 1'b0;
`ifdef UART_TX_MONITOR_PARITY_EN
    par_d   = par;
`endif
    unique case (state)
      IDLE: begin
        // Half-bit delay centres every later sample in its bit cell.
        if (fall) begin
          cnt_d   = HALF_BIT;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (!rx_s) begin
            cnt_d   = FULL_BIT;
            idx_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_d  = {rx_s, sh[DATA_BITS-1:1]};
          cnt_d = FULL_BIT;
          idx_d = idx + 1'b1;
          if (idx == LAST_BIT) state_d = AFTER_DATA;
        end
      end
`ifdef UART_TX_MONITOR_PARITY_EN
      PARITY: begin
        if (tick) begin
          par_d   = rx_s;
          cnt_d   = FULL_BIT;
          state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          ferr    = ~rx_s | (^{sh, par});
          push    = ~ferr;
          state_d = rx_s ? IDLE : BREAK;
        end
      end
`else
      STOP: begin
        if (tick) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr    = 1'b1;
            state_d = BREAK;
          end
        end
      end
`endif
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop     = valid_o & ready_i;
  assign push_ok = push & (~full | pop);
  assign valid_o = ~empty;

  uart_tx_monitor_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .wdata (sh),
    .pop   (pop),
    .rdata (data_o),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      frame_err_o <= 1'b0;
      overflow_o  <= 1'b0;
      eot_o       <= 1'b0;
      rx_count_o  <= '0;
    end else begin
      frame_err_o <= ferr;
      overflow_o  <= push & full & ~pop;
      if (push_ok) begin
        rx_count_o <= rx_count_o + 1'b1;
        if (sh == EOT_CHAR) eot_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Directed bench for uart_tx_monitor: byte-queue scoreboard plus literal checks.
// Compile with UART_TX_MONITOR_PARITY_EN to exercise 8E1 framing.
module tb_uart_tx_monitor;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rx_i = 1'b1;
  logic        ready_i = 1'b1;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        frame_err_o;
  logic        overflow_o;
  logic        eot_o;
  logic        busy_o;
  logic [15:0] rx_count_o;

  always #5 clk = ~clk;

  uart_tx_monitor #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .EOT_CHAR     (8'h04)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rx_i        (rx_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overflow_o  (overflow_o),
    .eot_o       (eot_o),
    .busy_o      (busy_o),
    .rx_count_o  (rx_count_o)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_q[$];
  int   exp_count = 0;
  logic exp_eot   = 1'b0;
  int   exp_ferr  = 0;
  int   exp_ovf   = 0;
  int   ferr_seen = 0;
  int   ovf_seen  = 0;
  int   pops      = 0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endfunction

  // Scoreboard: every accepted byte must match the model queue head.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (valid_o && ready_i) begin
        pops++;
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL pop_unexpected: got %0h, want none", data_o);
        end else begin
          check("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
        end
      end
      if (frame_err_o) ferr_seen++;
      if (overflow_o)  ovf_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic v, input int n);
    rx_i = v;
    cyc(CPB * n);
  endtask

  // Model of a frame's effect: decided from framing rules and occupancy.
  task automatic model_frame(input logic [7:0] b, input logic good);
    if (!good) begin
      exp_ferr++;
    end else if (!ready_i && exp_q.size() == DEPTH) begin
      exp_ovf++;
    end else begin
      exp_q.push_back(b);
      exp_count = (exp_count + 1) % 65536;
      if (b == 8'h04) exp_eot = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int stop_bits, input logic par_flip);
    send_bit(1'b0, 1);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1);
`ifdef UART_TX_MONITOR_PARITY_EN
    send_bit((^b) ^ par_flip, 1);
`endif
    model_frame(b, stop_v && !par_flip);
    send_bit(stop_v, stop_bits);
    rx_i = 1'b1;
  endtask

  task automatic quiet(input string tag);
    cyc(2 * CPB);
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_count"}, 32'(rx_count_o), 32'(exp_count));
    check({tag, "_eot"}, 32'(eot_o), 32'(exp_eot));
    check({tag, "_valid"}, 32'(valid_o), 32'(exp_q.size() != 0));
    check({tag, "_ferr"}, 32'(ferr_seen), 32'(exp_ferr));
    check({tag, "_ovf"}, 32'(ovf_seen), 32'(exp_ovf));
    cyc(1);
  endtask

  task automatic reset_values(input string tag);
    @(negedge clk);
    check({tag, "_valid"}, 32'(valid_o), 0);
    check({tag, "_data"}, 32'(data_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_count"}, 32'(rx_count_o), 0);
    check({tag, "_eot"}, 32'(eot_o), 0);
    check({tag, "_ferr"}, 32'(frame_err_o), 0);
    check({tag, "_ovf"}, 32'(overflow_o), 0);
  endtask

  initial begin
    cyc(3);
    reset_values("rst");
    cyc(1);
    rst_ni = 1'b1;
    cyc(2 * CPB);

    send_frame(8'h55, 1'b1, 1, 1'b0);
    quiet("t1");
    check("t1_count_lit", 32'(rx_count_o), 1);
    check("t1_pops_lit", 32'(pops), 1);

    send_frame(8'h48, 1'b1, 1, 1'b0);
    send_frame(8'h69, 1'b1, 1, 1'b0);
    send_frame(8'h04, 1'b1, 1, 1'b0);
    quiet("t2");
    check("t2_eot_lit", 32'(eot_o), 1);
    check("t2_count_lit", 32'(rx_count_o), 4);
    cyc(4 * CPB);
    check("t2_eot_sticky", 32'(eot_o), 1);

    ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 1, 1'b0);
    send_frame(8'h22, 1'b1, 1, 1'b0);
    send_frame(8'h33, 1'b1, 1, 1'b0);
    send_frame(8'h44, 1'b1, 1, 1'b0);
    send_frame(8'hEE, 1'b1, 1, 1'b0);
    quiet("t3");
    check("t3_ovf_lit", 32'(ovf_seen), 1);
    check("t3_count_lit", 32'(rx_count_o), 8);
    check("t3_full_head", 32'(data_o), 32'h11);
    ready_i = 1'b1;
    cyc(20);
    check("t3_pops_lit", 32'(pops), 8);
    check("t3_drained", 32'(valid_o), 0);

    send_frame(8'hA5, 1'b0, 1, 1'b0);
    rx_i = 1'b0;
    cyc(CPB);
    @(negedge clk);
    check("t4_break_busy", 32'(busy_o), 1);
    cyc(1);
    rx_i = 1'b1;
    quiet("t4");
    check("t4_ferr_lit", 32'(ferr_seen), 1);
    send_frame(8'h3C, 1'b1, 1, 1'b0);
    quiet("t4b");
    check("t4_count_lit", 32'(rx_count_o), 9);

    rx_i = 1'b0;
    cyc(4);
    rx_i = 1'b1;
    cyc(2);
    @(negedge clk);
    check("t5_start_busy", 32'(busy_o), 1);
    cyc(1);
    quiet("t5");

    rx_i = 1'b0;
    cyc(CPB);
    rx_i = 1'b1;
    cyc(3 * CPB);
    @(negedge clk);
    check("t6_mid_busy", 32'(busy_o), 1);
    cyc(1);
    rst_ni = 1'b0;
    exp_q.delete();
    exp_count = 0;
    exp_eot   = 1'b0;
    cyc(2);
    reset_values("t6_rst");
    cyc(1);
    rst_ni = 1'b1;
    cyc(2 * CPB);
    send_frame(8'h12, 1'b1, 1, 1'b0);
    quiet("t6");
    check("t6_count_lit", 32'(rx_count_o), 1);

`ifdef UART_TX_MONITOR_PARITY_EN
    send_frame(8'h07, 1'b1, 1, 1'b0);
    quiet("t7a");
    check("t7_count_lit", 32'(rx_count_o), 2);
    send_frame(8'h07, 1'b1, 1, 1'b1);
    quiet("t7b");
    check("t7_ferr_lit", 32'(ferr_seen), 2);
    check("t7_nopush", 32'(rx_count_o), 2);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
